// File: rtl/ex_hazard_ctrl_if.sv
// Execute-stage hazard control bus: EX/ID status in, stall/flush/redirect out.
// The controller takes the slave side and the core pipeline takes the master side.
interface ex_hazard_ctrl_if #(
  parameter int unsigned PC_W = 16
);
  logic            ex_valid;
  logic            ex_branch;
  logic [PC_W-1:0] ex_pc;
  logic            ex_halt;
  logic            ex_memread;
  logic            ex_regwrite;
  logic [2:0]      ex_writereg;
  logic            id_valid;
  logic [2:0]      id_rs;
  logic [2:0]      id_rt;
  logic            id_uses_rs;
  logic            id_uses_rt;

  logic            pc_stall;
  logic            ifid_stall;
  logic            ifid_flush;
  logic            idex_flush;
  logic            pc_redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halted;
  logic [15:0]     redirect_cnt;

  modport master (
    output ex_valid, ex_branch, ex_pc, ex_halt, ex_memread, ex_regwrite,
           ex_writereg, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  pc_stall, ifid_stall, ifid_flush, idex_flush, pc_redirect,
           redirect_pc, halted, redirect_cnt
  );

  modport slave (
    input  ex_valid, ex_branch, ex_pc, ex_halt, ex_memread, ex_regwrite,
           ex_writereg, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output pc_stall, ifid_stall, ifid_flush, idex_flush, pc_redirect,
           redirect_pc, halted, redirect_cnt
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage pipeline controller: sequences taken-branch redirects, load-use
// bubbles and HALT, driving PC/IF-ID stall, IF-ID/ID-EX flush and PC redirect.
module ex_hazard_ctrl #(
  parameter int unsigned LDUSE_STALL = 1,
  parameter int unsigned PC_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ex_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_REDIR,
    ST_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      stall_cnt_q, stall_cnt_d;
  logic [PC_W-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]     redirect_cnt_q, redirect_cnt_d;

  logic hz;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_flush_c;
  logic pc_redirect_c, halted_c;

  assign hz = bus.ex_valid & bus.ex_memread & bus.ex_regwrite & bus.id_valid &
              ((bus.id_uses_rs & (bus.id_rs == bus.ex_writereg)) |
               (bus.id_uses_rt & (bus.id_rt == bus.ex_writereg)));

  always_comb begin
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    redirect_pc_d  = redirect_pc_q;
    redirect_cnt_d = redirect_cnt_q;
    pc_stall_c     = 1'b0;
    ifid_stall_c   = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_flush_c   = 1'b0;
    pc_redirect_c  = 1'b0;
    halted_c       = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.ex_valid && bus.ex_halt) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          state_d      = ST_HALT;
        end else if (bus.ex_valid && bus.ex_branch) begin
          // Counted on entry so the count already reads updated during REDIR.
          ifid_flush_c   = 1'b1;
          idex_flush_c   = 1'b1;
          redirect_pc_d  = bus.ex_pc;
          redirect_cnt_d = redirect_cnt_q + 16'd1;
          state_d        = ST_REDIR;
        end else if (hz) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
          if (LDUSE_STALL > 1) begin
            stall_cnt_d = 2'(LDUSE_STALL - 1);
            state_d     = ST_LDSTALL;
          end
        end
      end
      ST_LDSTALL: begin
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_flush_c = 1'b1;
        stall_cnt_d  = stall_cnt_q - 2'd1;
        if (stall_cnt_q == 2'd1) state_d = ST_RUN;
      end
      ST_REDIR: begin
        pc_redirect_c = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        state_d       = ST_RUN;
      end
      ST_HALT: begin
        halted_c     = 1'b1;
        pc_stall_c   = 1'b1;
        ifid_stall_c = 1'b1;
        idex_flush_c = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      stall_cnt_q    <= '0;
      redirect_pc_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      stall_cnt_q    <= stall_cnt_d;
      redirect_pc_q  <= redirect_pc_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  // Control strobes depend on live EX inputs, so gate them with rst_n to drop at once.
  assign bus.pc_stall     = rst_n & pc_stall_c;
  assign bus.ifid_stall   = rst_n & ifid_stall_c;
  assign bus.ifid_flush   = rst_n & ifid_flush_c;
  assign bus.idex_flush   = rst_n & idex_flush_c;
  assign bus.pc_redirect  = rst_n & pc_redirect_c;
  assign bus.halted       = rst_n & halted_c;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: two instances (1 and 3 load-use bubbles)
// share one stimulus stream; outputs are checked 1 ns after each falling edge.
module tb_ex_hazard_ctrl;
  localparam int unsigned PC_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ex_hazard_ctrl_if #(.PC_W(PC_W)) b1 ();
  ex_hazard_ctrl_if #(.PC_W(PC_W)) b3 ();

  ex_hazard_ctrl #(.LDUSE_STALL(1), .PC_W(PC_W)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ex_hazard_ctrl #(.LDUSE_STALL(3), .PC_W(PC_W)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // {pc_stall, ifid_stall, ifid_flush, idex_flush, pc_redirect, halted}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b110100;
  localparam logic [5:0] O_BR    = 6'b001100;
  localparam logic [5:0] O_REDIR = 6'b001110;
  localparam logic [5:0] O_HALT  = 6'b110101;

  function automatic logic [5:0] o1();
    return {b1.pc_stall, b1.ifid_stall, b1.ifid_flush, b1.idex_flush, b1.pc_redirect, b1.halted};
  endfunction

  function automatic logic [5:0] o3();
    return {b3.pc_stall, b3.ifid_stall, b3.ifid_flush, b3.idex_flush, b3.pc_redirect, b3.halted};
  endfunction

  task automatic set_in(input logic v, input logic br, input logic [PC_W-1:0] pc,
                        input logic halt, input logic mr, input logic rw,
                        input logic [2:0] wr, input logic idv, input logic [2:0] rs,
                        input logic [2:0] rt, input logic urs, input logic urt);
    b1.ex_valid = v;   b3.ex_valid = v;
    b1.ex_branch = br; b3.ex_branch = br;
    b1.ex_pc = pc;     b3.ex_pc = pc;
    b1.ex_halt = halt; b3.ex_halt = halt;
    b1.ex_memread = mr;  b3.ex_memread = mr;
    b1.ex_regwrite = rw; b3.ex_regwrite = rw;
    b1.ex_writereg = wr; b3.ex_writereg = wr;
    b1.id_valid = idv;   b3.id_valid = idv;
    b1.id_rs = rs;       b3.id_rs = rs;
    b1.id_rt = rt;       b3.id_rt = rt;
    b1.id_uses_rs = urs; b3.id_uses_rs = urs;
    b1.id_uses_rt = urt; b3.id_uses_rt = urt;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_IDLE) begin n_fail++; $display("FAIL reset_hold outs=%b exp=%b", o1(), O_IDLE); end
    n_tests++;
    if (b1.redirect_cnt !== 16'h0000 || b1.redirect_pc !== 16'h0000) begin
      n_fail++; $display("FAIL reset_regs cnt=%h pc=%h exp=0000/0000", b1.redirect_cnt, b1.redirect_pc);
    end
    @(negedge clk); idle(); rst_n = 1'b1; #1;
    n_tests++;
    if (o1() !== O_IDLE) begin n_fail++; $display("FAIL reset_release outs=%b exp=%b", o1(), O_IDLE); end
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_BR) begin n_fail++; $display("FAIL reset_pre_br outs=%b exp=%b", o1(), O_BR); end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (o1() !== O_REDIR || b1.redirect_pc !== 16'h1234) begin
      n_fail++; $display("FAIL reset_pre_redir outs=%b pc=%h exp=%b/1234", o1(), b1.redirect_pc, O_REDIR);
    end
    #2 rst_n = 1'b0; #1;
    n_tests++;
    if (o1() !== O_IDLE || b1.redirect_pc !== 16'h0000 || b1.redirect_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL reset_mid_redir outs=%b pc=%h cnt=%h exp=000000/0000/0000",
                         o1(), b1.redirect_pc, b1.redirect_cnt);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    @(negedge clk); #1;
    n_tests++;
    if (o1() !== O_IDLE || b1.redirect_cnt !== 16'h0000) begin
      n_fail++; $display("FAIL reset_after outs=%b cnt=%h exp=000000/0000", o1(), b1.redirect_cnt);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_BR) begin n_fail++; $display("FAIL branch_n outs=%b exp=%b", o1(), O_BR); end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (o1() !== O_REDIR || b1.redirect_pc !== 16'h0040 || b1.redirect_cnt !== 16'd1) begin
      n_fail++; $display("FAIL branch_n1 outs=%b pc=%h cnt=%0d exp=%b/0040/1",
                         o1(), b1.redirect_pc, b1.redirect_cnt, O_REDIR);
    end
    @(negedge clk); #1;
    n_tests++;
    if (o1() !== O_IDLE || b1.redirect_pc !== 16'h0040) begin
      n_fail++; $display("FAIL branch_n2 outs=%b pc=%h exp=%b/0040", o1(), b1.redirect_pc, O_IDLE);
    end
  endtask

  task automatic test_loaduse();
    // rs hazard: b1 stalls once, b3 three times even with EX empty afterwards
    @(negedge clk);
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 3'd0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_STALL || o3() !== O_STALL) begin
      n_fail++; $display("FAIL lduse_c1 b1=%b b3=%b exp=%b/%b", o1(), o3(), O_STALL, O_STALL);
    end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); b1.ex_valid = 1'b0; b3.ex_valid = 1'b0; #1;
      n_tests++;
      if (o1() !== O_IDLE || o3() !== O_STALL) begin
        n_fail++; $display("FAIL lduse_c%0d b1=%b b3=%b exp=%b/%b", i, o1(), o3(), O_IDLE, O_STALL);
      end
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (o1() !== O_IDLE || o3() !== O_IDLE) begin
      n_fail++; $display("FAIL lduse_done b1=%b b3=%b exp=%b", o1(), o3(), O_IDLE);
    end
    // same registers but rs not read
    @(negedge clk);
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_IDLE || o3() !== O_IDLE) begin
      n_fail++; $display("FAIL lduse_norsuse b1=%b b3=%b exp=%b", o1(), o3(), O_IDLE);
    end
    // load without register write is no hazard
    @(negedge clk);
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd3, 3'd3, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (o1() !== O_IDLE || o3() !== O_IDLE) begin
      n_fail++; $display("FAIL lduse_norw b1=%b b3=%b exp=%b", o1(), o3(), O_IDLE);
    end
    // rt hazard on register 6
    @(negedge clk);
    set_in(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 3'd5, 3'd6, 1'b1, 1'b1);
    #1;
    n_tests++;
    if (o1() !== O_STALL || o3() !== O_STALL) begin
      n_fail++; $display("FAIL lduse_rt b1=%b b3=%b exp=%b/%b", o1(), o3(), O_STALL, O_STALL);
    end
    @(negedge clk); idle();
    @(negedge clk); #1;
    n_tests++;
    if (o3() !== O_STALL) begin n_fail++; $display("FAIL lduse_rt_c3 b3=%b exp=%b", o3(), O_STALL); end
    @(negedge clk); #1;
    n_tests++;
    if (o3() !== O_IDLE) begin n_fail++; $display("FAIL lduse_rt_done b3=%b exp=%b", o3(), O_IDLE); end
  endtask

  task automatic test_priority();
    // branch with simultaneous hazard: hazard discarded, also during REDIR
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h0080, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 3'd2, 3'd0, 1'b1, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_BR || o3() !== O_BR) begin
      n_fail++; $display("FAIL prio_brhz b1=%b b3=%b exp=%b", o1(), o3(), O_BR);
    end
    @(negedge clk); #1;
    n_tests++;
    if (o1() !== O_REDIR || o3() !== O_REDIR || b1.redirect_pc !== 16'h0080 || b1.redirect_cnt !== 16'd2) begin
      n_fail++; $display("FAIL prio_brhz_redir b1=%b b3=%b pc=%h cnt=%0d exp=%b/0080/2",
                         o1(), o3(), b1.redirect_pc, b1.redirect_cnt, O_REDIR);
    end
    @(negedge clk); idle(); #1;
    n_tests++;
    if (o1() !== O_IDLE || o3() !== O_IDLE) begin
      n_fail++; $display("FAIL prio_brhz_done b1=%b b3=%b exp=%b", o1(), o3(), O_IDLE);
    end
    // halt with simultaneous branch: halt wins, no redirect ever
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h00C0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    #1;
    n_tests++;
    if (o1() !== O_STALL || o3() !== O_STALL) begin
      n_fail++; $display("FAIL prio_halt b1=%b b3=%b exp=%b", o1(), o3(), O_STALL);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
      #1;
      n_tests++;
      if (o1() !== O_HALT || o3() !== O_HALT || b1.redirect_cnt !== 16'd2 || b1.redirect_pc !== 16'h0080) begin
        n_fail++; $display("FAIL prio_halted_%0d b1=%b b3=%b cnt=%0d pc=%h exp=%b/2/0080",
                           i, o1(), o3(), b1.redirect_cnt, b1.redirect_pc, O_HALT);
      end
    end
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    n_tests++;
    if (o1() !== O_IDLE) begin n_fail++; $display("FAIL prio_halt_reset outs=%b exp=%b", o1(), O_IDLE); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    n_tests++;
    if (o1() !== O_IDLE || o3() !== O_IDLE) begin
      n_fail++; $display("FAIL prio_after_reset b1=%b b3=%b exp=%b", o1(), o3(), O_IDLE);
    end
  endtask

  task automatic test_cnt_wrap();
    @(negedge clk); idle();
    force u_dut1.redirect_cnt_q = 16'hFFFF;
    #1 release u_dut1.redirect_cnt_q;
    @(negedge clk); #1;
    n_tests++;
    if (b1.redirect_cnt !== 16'hFFFF) begin
      n_fail++; $display("FAIL wrap_preload cnt=%h exp=ffff", b1.redirect_cnt);
    end
    @(negedge clk);
    set_in(1'b1, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    @(negedge clk); idle(); #1;
    n_tests++;
    if (b1.redirect_cnt !== 16'h0000 || b3.redirect_cnt !== 16'h0001 || o1() !== O_REDIR) begin
      n_fail++; $display("FAIL wrap_cnt b1cnt=%h b3cnt=%h outs=%b exp=0000/0001/%b",
                         b1.redirect_cnt, b3.redirect_cnt, o1(), O_REDIR);
    end
    @(negedge clk); #1;
    n_tests++;
    if (o1() !== O_IDLE || b1.redirect_pc !== 16'h0010) begin
      n_fail++; $display("FAIL wrap_done outs=%b pc=%h exp=%b/0010", o1(), b1.redirect_pc, O_IDLE);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      n_tests++;
      if ((b1.ifid_stall && b1.ifid_flush) || (b1.pc_redirect && b1.pc_stall) ||
          (b3.ifid_stall && b3.ifid_flush) || (b3.pc_redirect && b3.pc_stall)) begin
        n_fail++; $display("FAIL exclusive b1=%b b3=%b at %0t", o1(), o3(), $time);
      end
    end
  end

  initial begin
    idle();
    test_reset();
    test_branch();
    test_loaduse();
    test_priority();
    test_cnt_wrap();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
